mux8_serial_ctrl: RTL and testbench

MUX8_SERIAL_CTRL -- requirements
Module: mux8_serial_ctrl

---
 rtl/mux8_serial_ctrl_if.sv | 27 ++
 rtl/mux8_serial_ctrl.sv | 101 ++++++++++
 tb/tb_mux8_serial_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mux8_serial_ctrl_if.sv
// Bus between the serializer controller and its environment: request side,
// the 8:1 mux drive/return pair, and the reconstructed-word status outputs.
interface mux8_serial_ctrl_if;
   logic       start;
   logic [7:0] data_in;
   logic       msb_first;
   logic       abort;
   logic [7:0] mux_in;
   logic [2:0] sel;
   logic       mux_out;
   logic       ser_valid;
   logic       ser_bit;
   logic [7:0] rx_word;
   logic       done;
   logic       mismatch;
   logic       busy;

   modport master (
      output start, data_in, msb_first, abort, mux_out,
      input  mux_in, sel, ser_valid, ser_bit, rx_word, done, mismatch, busy
   );

   modport slave (
      input  start, data_in, msb_first, abort, mux_out,
      output mux_in, sel, ser_valid, ser_bit, rx_word, done, mismatch, busy
   );
endinterface

// File: rtl/mux8_serial_ctrl.sv
// Walks a downstream 8:1 mux through all eight inputs, holding each select for
// HOLD cycles, and rebuilds the word from the sampled mux output.
module mux8_serial_ctrl #(
   parameter int unsigned HOLD = 1
) (
   input logic               clk,
   input logic               rst,
   mux8_serial_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

   state_t     state, state_nxt;
   logic       order;
   logic [3:0] hold_cnt;
   logic [2:0] sel;
   logic [7:0] mux_in;
   logic [7:0] rx_word;
   logic       ser_bit;
   logic       accept;
   logic       sample;
   logic       last_bit;

   // The final index is the far end of the sweep, so sel itself counts bits.
   assign last_bit = order ? (sel == 3'd0) : (sel == 3'd7);

   // NOTE: every signal gets a default before the case; a path that leaves one
   // unassigned would infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      sample    = 1'b0;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  accept    = 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = IDLE;
               end
            end
            SHIFT: begin
               if (hold_cnt == HOLD_LAST) begin
                  sample = 1'b1;
                  if (last_bit) state_nxt = DONE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mux_in   <= 8'h00;
         order    <= 1'b0;
         sel      <= 3'd0;
         hold_cnt <= 4'd0;
         rx_word  <= 8'h00;
         ser_bit  <= 1'b0;
      end else if (accept) begin
         mux_in   <= bus.data_in;
         order    <= bus.msb_first;
         sel      <= bus.msb_first ? 3'd7 : 3'd0;
         hold_cnt <= 4'd0;
         rx_word  <= 8'h00;
      end else if (state == SHIFT && !bus.abort) begin
         if (sample) begin
            rx_word[sel] <= bus.mux_out;
            ser_bit      <= bus.mux_out;
            hold_cnt     <= 4'd0;
            if (!last_bit) sel <= order ? sel - 3'd1 : sel + 3'd1;
         end else begin
            hold_cnt <= hold_cnt + 4'd1;
         end
      end
   end

   // Status outputs are decoded from registers only; mux_out never reaches them.
   assign bus.mux_in    = mux_in;
   assign bus.sel       = sel;
   assign bus.rx_word   = rx_word;
   assign bus.ser_bit   = ser_bit;
   assign bus.ser_valid = (state == SHIFT);
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.mismatch  = (state == DONE) && (rx_word != mux_in);

endmodule

// File: tb/tb_mux8_serial_ctrl.sv
// Directed bench: one controller with HOLD=1 and one with HOLD=3, each driving
// an ideal 8:1 mux model (the HOLD=1 model can have input 4 stuck at 0).
module tb_mux8_serial_ctrl;
   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic stuck_a = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk = ~clk;

   mux8_serial_ctrl_if a_bus ();
   mux8_serial_ctrl_if b_bus ();

   assign a_bus.mux_out = (stuck_a && a_bus.sel == 3'd4) ? 1'b0 : a_bus.mux_in[a_bus.sel];
   assign b_bus.mux_out = b_bus.mux_in[b_bus.sel];

   mux8_serial_ctrl #(.HOLD(1)) u_dut_h1 (.clk(clk), .rst(rst), .bus(a_bus));
   mux8_serial_ctrl #(.HOLD(3)) u_dut_h3 (.clk(clk), .rst(rst), .bus(b_bus));

   // {busy, ser_valid, done, mismatch, ser_bit, sel}
   logic [7:0] a_flags, b_flags;
   assign a_flags = {a_bus.busy, a_bus.ser_valid, a_bus.done, a_bus.mismatch, a_bus.ser_bit, a_bus.sel};
   assign b_flags = {b_bus.busy, b_bus.ser_valid, b_bus.done, b_bus.mismatch, b_bus.ser_bit, b_bus.sel};

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      a_bus.start = 1'b0; a_bus.data_in = 8'h00; a_bus.msb_first = 1'b0; a_bus.abort = 1'b0;
      b_bus.start = 1'b0; b_bus.data_in = 8'h00; b_bus.msb_first = 1'b0; b_bus.abort = 1'b0;

      // Reset asserted before any clock edge
      #1 rst = 1'b1;
      #2;
      check("rst_a_flags", a_flags, 8'h00);
      check("rst_a_mux_in", a_bus.mux_in, 8'h00);
      check("rst_a_rx", a_bus.rx_word, 8'h00);
      check("rst_b_flags", b_flags, 8'h00);
      tick(2);
      rst = 1'b0;

      // HOLD=1, 0xA5 LSB first
      a_bus.start = 1'b1; a_bus.data_in = 8'hA5; a_bus.msb_first = 1'b0;
      tick(1);
      a_bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("h1_sel", 8'(a_bus.sel), 8'(i));
         check("h1_valid", 8'(a_bus.ser_valid), 8'd1);
         check("h1_no_done", 8'(a_bus.done), 8'd0);
         tick(1);
      end
      check("h1_done", 8'(a_bus.done), 8'd1);
      check("h1_rx", a_bus.rx_word, 8'hA5);
      check("h1_flags_done", a_flags, 8'b1010_1111);
      tick(1);
      check("h1_idle_flags", a_flags, 8'b0000_1111);
      check("h1_rx_hold", a_bus.rx_word, 8'hA5);

      // HOLD=3, 0x3C MSB first
      b_bus.start = 1'b1; b_bus.data_in = 8'h3C; b_bus.msb_first = 1'b1;
      tick(1);
      b_bus.start = 1'b0;
      for (int j = 0; j < 8; j++) begin
         for (int h = 0; h < 3; h++) begin
            check("h3_sel", 8'(b_bus.sel), 8'(7 - j));
            check("h3_no_done", 8'(b_bus.done), 8'd0);
            tick(1);
         end
      end
      check("h3_done", 8'(b_bus.done), 8'd1);
      check("h3_rx", b_bus.rx_word, 8'h3C);
      check("h3_flags_done", b_flags, 8'b1010_0000);
      tick(1);
      check("h3_idle_done", 8'(b_bus.done), 8'd0);

      // Stuck-at-0 on mux input 4
      stuck_a = 1'b1;
      a_bus.start = 1'b1; a_bus.data_in = 8'hFF; a_bus.msb_first = 1'b0;
      tick(1);
      a_bus.start = 1'b0;
      tick(4);
      check("stuck_mismatch_mid", 8'(a_bus.mismatch), 8'd0);
      tick(4);
      check("stuck_done", 8'(a_bus.done), 8'd1);
      check("stuck_rx", a_bus.rx_word, 8'hEF);
      check("stuck_mismatch", 8'(a_bus.mismatch), 8'd1);
      tick(1);
      check("stuck_mismatch_after", 8'(a_bus.mismatch), 8'd0);
      stuck_a = 1'b0;

      // Abort beats start in IDLE
      a_bus.start = 1'b1; a_bus.abort = 1'b1; a_bus.data_in = 8'h11;
      tick(1);
      check("abort_prio_busy", 8'(a_bus.busy), 8'd0);
      check("abort_prio_mux_in", a_bus.mux_in, 8'hFF);
      a_bus.start = 1'b0; a_bus.abort = 1'b0;

      // Abort in the 4th SHIFT cycle of 0x81
      a_bus.start = 1'b1; a_bus.data_in = 8'h81;
      tick(1);
      a_bus.start = 1'b0;
      tick(3);
      a_bus.abort = 1'b1;
      tick(1);
      check("abort_flags", {a_flags[7:5], 5'd0}, 8'h00);
      check("abort_rx", a_bus.rx_word, 8'h01);
      check("abort_mux_in", a_bus.mux_in, 8'h81);
      a_bus.abort = 1'b0;
      tick(1);
      check("abort_no_done", 8'(a_bus.done), 8'd0);
      a_bus.start = 1'b1; a_bus.data_in = 8'h7E;
      tick(1);
      a_bus.start = 1'b0;
      tick(8);
      check("after_abort_done", 8'(a_bus.done), 8'd1);
      check("after_abort_rx", a_bus.rx_word, 8'h7E);
      check("after_abort_mismatch", 8'(a_bus.mismatch), 8'd0);
      tick(1);

      // Back-to-back: start 0x55 in the DONE cycle of 0xAA
      a_bus.start = 1'b1; a_bus.data_in = 8'hAA;
      tick(1);
      a_bus.start = 1'b0;
      tick(7);
      check("b2b_pre_done", 8'(a_bus.done), 8'd0);
      tick(1);
      check("b2b_done1", 8'(a_bus.done), 8'd1);
      check("b2b_rx1", a_bus.rx_word, 8'hAA);
      a_bus.start = 1'b1; a_bus.data_in = 8'h55;
      tick(1);
      check("b2b_restart_flags", {a_flags[7:5], 2'b00, a_bus.sel}, 8'b1100_0000);
      check("b2b_mux_in", a_bus.mux_in, 8'h55);
      check("b2b_rx_clr", a_bus.rx_word, 8'h00);
      a_bus.data_in = 8'h00;
      tick(1);
      check("shift_start_ignored", a_bus.mux_in, 8'h55);
      check("shift_sel_step", 8'(a_bus.sel), 8'd1);
      a_bus.start = 1'b0;
      tick(7);
      check("b2b_done2", 8'(a_bus.done), 8'd1);
      check("b2b_rx2", a_bus.rx_word, 8'h55);
      tick(1);

      // Async reset mid-SHIFT with start held high throughout
      b_bus.start = 1'b1; b_bus.data_in = 8'h5A; b_bus.msb_first = 1'b0;
      tick(5);
      check("rst_mid_busy", 8'(b_bus.busy), 8'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_b_flags", b_flags, 8'h00);
      check("rst_async_b_mux_in", b_bus.mux_in, 8'h00);
      check("rst_async_b_rx", b_bus.rx_word, 8'h00);
      tick(1);
      check("rst_held_busy", 8'(b_bus.busy), 8'd0);
      rst = 1'b0;
      tick(1);
      check("post_rst_accept", 8'(b_bus.busy), 8'd1);
      check("post_rst_mux_in", b_bus.mux_in, 8'h5A);
      b_bus.start = 1'b0;
      tick(24);
      check("post_rst_done", 8'(b_bus.done), 8'd1);
      check("post_rst_rx", b_bus.rx_word, 8'h5A);
      tick(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
